// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int PC_W = 9;
  localparam logic [PC_W-1:0] RESET_PC  = 9'h000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc4;
  } fetch_word_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return p + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks a fetched word while the pipeline is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        valid
);

  // Cleared contents equal a bubble, so a stray read never leaks stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '{instr: NOP_INSTR, pc4: '0};
      valid <= 1'b0;
    end else if (clear) begin
      dout  <= '{instr: NOP_INSTR, pc4: '0};
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request sequencing, stall capture, redirect/flush, IF/ID register.
module fetch_stage
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  pc,
  output logic [31:0]      if_id_instr,
  output logic [PC_W-1:0]  if_id_pc4,
  output logic             if_id_valid,
  output fetch_state_t     dbg_state
);

  // Handshake: imem_req/imem_addr are held stable from the cycle req rises until
  // the cycle imem_ack is seen high; imem_rdata is consumed only in that ack cycle.

  fetch_state_t    state, state_nx;
  logic [PC_W-1:0] pc_nx, kill_addr, kill_nx, pc_plus4;
  logic [31:0]     instr_nx;
  logic [PC_W-1:0] pc4_nx;
  logic            valid_nx;
  logic            buf_load, buf_clear, buf_valid;
  fetch_word_t     buf_din, buf_dout;

  assign pc_plus4  = pc_inc(pc);
  assign imem_req  = rst_n && (state == FETCH || state == KILL);
  assign imem_addr = (state == KILL) ? kill_addr : pc;
  assign dbg_state = state;
  assign buf_din   = '{instr: imem_rdata, pc4: pc_plus4};

  fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (buf_din),
    .dout  (buf_dout),
    .valid (buf_valid)
  );

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    kill_nx   = kill_addr;
    instr_nx  = if_id_instr;
    pc4_nx    = if_id_pc4;
    valid_nx  = if_id_valid;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_nx    = redirect_pc;
          instr_nx = NOP_INSTR;
          pc4_nx   = '0;
          valid_nx = 1'b0;
          if (!imem_ack) begin
            // The outstanding request must complete before the new path can issue.
            kill_nx  = pc;
            state_nx = KILL;
          end
        end else if (stall) begin
          if (imem_ack) begin
            buf_load = 1'b1;
            pc_nx    = pc_plus4;
            state_nx = HOLD;
          end
        end else if (imem_ack) begin
          instr_nx = imem_rdata;
          pc4_nx   = pc_plus4;
          valid_nx = 1'b1;
          pc_nx    = pc_plus4;
        end else begin
          instr_nx = NOP_INSTR;
          pc4_nx   = '0;
          valid_nx = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nx     = redirect_pc;
          instr_nx  = NOP_INSTR;
          pc4_nx    = '0;
          valid_nx  = 1'b0;
          buf_clear = 1'b1;
          state_nx  = FETCH;
        end else if (!stall) begin
          instr_nx  = buf_dout.instr;
          pc4_nx    = buf_dout.pc4;
          valid_nx  = buf_valid;
          buf_clear = 1'b1;
          state_nx  = FETCH;
        end
      end
      KILL: begin
        if (redirect) pc_nx = redirect_pc;
        if (imem_ack) begin
          state_nx = FETCH;
          if (!stall) begin
            instr_nx = NOP_INSTR;
            pc4_nx   = '0;
            valid_nx = 1'b0;
          end
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      kill_addr   <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      kill_addr   <= kill_nx;
      if_id_instr <= instr_nx;
      if_id_pc4   <= pc4_nx;
      if_id_valid <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, wait states, stall capture, redirect/kill, wrap, async reset.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             stall;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [PC_W-1:0]  pc;
  logic [31:0]      if_id_instr;
  logic [PC_W-1:0]  if_id_pc4;
  logic             if_id_valid;
  fetch_state_t     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: every word reads back as its own address.
  assign imem_rdata = {23'h0, imem_addr};

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [PC_W-1:0] pc4, input logic valid);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   32'(if_id_pc4), 32'(pc4));
    check({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    check("rst.pc", 32'(pc), 32'h0);
    check("rst.req", 32'(imem_req), 32'h0);
    check("rst.state", 32'(dbg_state), 32'(FETCH));
    check_ifid("rst", 32'h0, 9'h0, 1'b0);

    // Zero-wait streaming
    rst_n = 1'b1; imem_ack = 1'b1;
    #1;
    check("strm.req", 32'(imem_req), 32'h1);
    check("strm.addr0", 32'(imem_addr), 32'h0);
    step(); check_ifid("strm0", 32'h0, 9'h004, 1'b1); check("strm0.pc", 32'(pc), 32'h4);
    step(); check_ifid("strm1", 32'h4, 9'h008, 1'b1); check("strm1.pc", 32'(pc), 32'h8);
    step(); check_ifid("strm2", 32'h8, 9'h00C, 1'b1); check("strm2.pc", 32'(pc), 32'hC);

    // Ack every third cycle
    imem_ack = 1'b0;
    step(); check_ifid("wait0", 32'h0, 9'h0, 1'b0); check("wait0.addr", 32'(imem_addr), 32'hC);
    check("wait0.req", 32'(imem_req), 32'h1);
    step(); check_ifid("wait1", 32'h0, 9'h0, 1'b0); check("wait1.addr", 32'(imem_addr), 32'hC);
    imem_ack = 1'b1;
    step(); check_ifid("wait2", 32'hC, 9'h010, 1'b1); check("wait2.pc", 32'(pc), 32'h10);

    // Stall coincident with ack at 0x10
    stall = 1'b1;
    step(); check("hold0.state", 32'(dbg_state), 32'(HOLD)); check("hold0.req", 32'(imem_req), 32'h0);
    check_ifid("hold0", 32'hC, 9'h010, 1'b1); check("hold0.pc", 32'(pc), 32'h14);
    imem_ack = 1'b0;
    step(); check_ifid("hold1", 32'hC, 9'h010, 1'b1); check("hold1.req", 32'(imem_req), 32'h0);
    step(); check_ifid("hold2", 32'hC, 9'h010, 1'b1); check("hold2.state", 32'(dbg_state), 32'(HOLD));
    stall = 1'b0;
    step(); check_ifid("unhold", 32'h10, 9'h014, 1'b1); check("unhold.state", 32'(dbg_state), 32'(FETCH));
    check("unhold.addr", 32'(imem_addr), 32'h14); check("unhold.req", 32'(imem_req), 32'h1);

    // Advance to 0x20, then redirect to 0x40 while 0x20 is unacked
    imem_ack = 1'b1;
    step(); step(); step();
    check_ifid("adv", 32'h1C, 9'h020, 1'b1); check("adv.pc", 32'(pc), 32'h20);
    imem_ack = 1'b0;
    step(); check("pend.addr", 32'(imem_addr), 32'h20);
    redirect = 1'b1; redirect_pc = 9'h040;
    step(); check("kill0.state", 32'(dbg_state), 32'(KILL)); check("kill0.pc", 32'(pc), 32'h40);
    check("kill0.addr", 32'(imem_addr), 32'h20); check("kill0.req", 32'(imem_req), 32'h1);
    check_ifid("kill0", 32'h0, 9'h0, 1'b0);
    redirect = 1'b0;
    step(); check("kill1.addr", 32'(imem_addr), 32'h20); check("kill1.state", 32'(dbg_state), 32'(KILL));
    imem_ack = 1'b1;
    step(); check_ifid("kill_ack", 32'h0, 9'h0, 1'b0); check("kill_ack.state", 32'(dbg_state), 32'(FETCH));
    check("kill_ack.addr", 32'(imem_addr), 32'h40);
    step(); check_ifid("newpath", 32'h40, 9'h044, 1'b1); check("newpath.pc", 32'(pc), 32'h44);

    // Redirect + stall + ack: flush wins
    redirect = 1'b1; stall = 1'b1; redirect_pc = 9'h1F8;
    step(); check_ifid("rds", 32'h0, 9'h0, 1'b0); check("rds.pc", 32'(pc), 32'h1F8);
    check("rds.state", 32'(dbg_state), 32'(FETCH));
    redirect = 1'b0; stall = 1'b0;
    step(); check_ifid("pre_wrap", 32'h1F8, 9'h1FC, 1'b1); check("pre_wrap.pc", 32'(pc), 32'h1FC);
    step(); check_ifid("wrap", 32'h1FC, 9'h000, 1'b1); check("wrap.pc", 32'(pc), 32'h0);

    // Async reset while in KILL
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 9'h080;
    step(); check("k2.state", 32'(dbg_state), 32'(KILL)); check("k2.pc", 32'(pc), 32'h80);
    redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.pc", 32'(pc), 32'h0);
    check("arst.req", 32'(imem_req), 32'h0);
    check("arst.state", 32'(dbg_state), 32'(FETCH));
    check_ifid("arst", 32'h0, 9'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
